// File: rtl/serial_pattern_detector_pkg.sv
// Shared constants and fill-state encoding for the serial pattern detector.
// The overlap feature is selected by SEQDET_OVERLAP_EN and is left undefined by default.
package serial_pattern_detector_pkg;

   localparam int             DEF_PAT_W   = 4;
   localparam logic [3:0]     DEF_PATTERN = 4'b1011;
   localparam int             DEF_CNT_W   = 8;

   // Wide enough for a fill count of 0..16.
   localparam int             FILL_W      = 5;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_ARMED   = 2'd2
   } fill_state_e;

endpackage

// File: rtl/serial_pattern_detector_shift_window.sv
// PAT_W-bit shift register with enable and synchronous clear; LSB is the newest bit.
// Also exposes the post-shift value so the parent can compare it in the same cycle.
module serial_pattern_detector_shift_window #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         din,
   output logic [W-1:0] shifted,
   output logic [W-1:0] window
);

   logic [W-1:0] window_q;
   logic [W-1:0] window_d;

   assign shifted = {window_q[W-2:0], din};

   always_comb begin
      window_d = window_q;
      if (clr) begin
         window_d = '0;
      end else if (en) begin
         window_d = shifted;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_q <= '0;
      end else begin
         window_q <= window_d;
      end
   end

   assign window = window_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: fill FSM, comparator, match pulse and saturating counter.
// Define SEQDET_OVERLAP_EN for overlapping detection; undefined gives non-overlapping detection.
module serial_pattern_detector
   import serial_pattern_detector_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic [PAT_W-1:0] window
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   fill_state_e       state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              match_q, match_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PAT_W-1:0]  shifted;
   logic              hit;

   serial_pattern_detector_shift_window #(
      .W (PAT_W)
   ) u_shift_window (
      .clk     (clk),
      .rst     (rst),
      .en      (din_valid),
      .clr     (clr),
      .din     (din),
      .shifted (shifted),
      .window  (window)
   );

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      count_d = count_q;
      hit     = 1'b0;
      if (clr) begin
         state_d = ST_EMPTY;
         fill_d  = '0;
         count_d = '0;
      end else if (din_valid) begin
         case (state_q)
            ST_EMPTY: begin
               state_d = ST_FILLING;
               fill_d  = FILL_W'(1);
            end
            ST_FILLING: begin
               fill_d = fill_q + 1'b1;
               if (fill_d == FILL_FULL) begin
                  state_d = ST_ARMED;
               end
            end
            ST_ARMED: begin
               fill_d = FILL_FULL;
            end
            default: begin
               state_d = ST_EMPTY;
               fill_d  = '0;
            end
         endcase
         // Candidate is the post-shift window, qualified by a full fill count.
         hit     = (fill_d == FILL_FULL) && (shifted == PATTERN);
         match_d = hit;
         if (hit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
         end
`ifndef SEQDET_OVERLAP_EN
         // Old window bits stay visible but need PAT_W fresh bits before they count again.
         if (hit) begin
            state_d = ST_EMPTY;
            fill_d  = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         fill_q  <= '0;
         match_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         count_q <= count_d;
      end
   end

   assign match       = match_q;
   assign match_count = count_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Randomized and directed bench for serial_pattern_detector against a queue-based reference model.
// Works for both builds of SEQDET_OVERLAP_EN; a second instance uses CNT_W=2 for saturation.
module tb_serial_pattern_detector;

   localparam int         PAT_W   = 4;
   localparam logic [3:0] PATTERN = 4'b1011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       clr = 1'b0;
   logic       match_a, match_b;
   logic [7:0] count_a;
   logic [1:0] count_b;
   logic [3:0] window_a, window_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
      .match(match_a), .match_count(count_a), .window(window_a)
   );

   serial_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
      .match(match_b), .match_count(count_b), .window(window_b)
   );

   // Reference model: last PAT_W valid bits in a queue, count of fresh bits since (re)start.
   bit   bits_q[$];
   int   since_start = 0;
   int   exp_cnt_a = 0;
   int   exp_cnt_b = 0;
   logic exp_match = 1'b0;
   int   exp_window = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bits_q.delete();
         since_start = 0;
         exp_cnt_a   = 0;
         exp_cnt_b   = 0;
         exp_match   = 1'b0;
         exp_window  = 0;
      end else if (clr) begin
         bits_q.delete();
         since_start = 0;
         exp_cnt_a   = 0;
         exp_cnt_b   = 0;
         exp_match   = 1'b0;
         exp_window  = 0;
      end else if (din_valid) begin
         bits_q.push_back(din);
         if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
         since_start++;
         exp_window = 0;
         foreach (bits_q[i]) exp_window = exp_window * 2 + int'(bits_q[i]);
         exp_match = (since_start >= PAT_W) && (exp_window == int'(PATTERN));
         if (exp_match) begin
            if (exp_cnt_a < 255) exp_cnt_a++;
            if (exp_cnt_b < 3) exp_cnt_b++;
`ifndef SEQDET_OVERLAP_EN
            since_start = 0;
`endif
         end
      end else begin
         exp_match = 1'b0;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cyc_match_a", int'(match_a), int'(exp_match));
      check("cyc_match_b", int'(match_b), int'(exp_match));
      check("cyc_count_a", int'(count_a), exp_cnt_a);
      check("cyc_count_b", int'(count_b), exp_cnt_b);
      check("cyc_window_a", int'(window_a), exp_window);
      check("cyc_window_b", int'(window_b), exp_window);
   end

   // Drive one cycle of inputs, then return just after the sampling edge.
   task automatic send(input logic b, input logic v, input logic c);
      @(negedge clk);
      #1;
      din = b;
      din_valid = v;
      clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, output int pulses);
      pulses = 0;
      for (int i = n - 1; i >= 0; i--) begin
         send(bits[i], 1'b1, 1'b0);
         pulses += int'(match_a);
      end
   endtask

   int pulses;
   int exp_pulses;

   initial begin
      rst = 1'b1;
      #12;
      check("reset_match", int'(match_a), 0);
      check("reset_count", int'(count_a), 0);
      check("reset_window", int'(window_a), 0);
      rst = 1'b0;

      // Async reset mid-stream, then a clean 1011.
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_window", int'(window_a), 0);
      check("rst_async_match", int'(match_a), 0);
      check("rst_async_count", int'(count_a), 0);
      rst = 1'b0;
      send_bits(16'b0000_0000_0000_1011, 4, pulses);
      check("rst_then_match", int'(match_a), 1);
      check("rst_then_pulses", pulses, 1);
      send(1'b0, 1'b0, 1'b0);
      check("pulse_no_stretch", int'(match_a), 0);

      // 1011011: two overlapping hits or one non-overlapping hit.
      send(1'b0, 1'b0, 1'b1);
      send_bits(16'b0000_0000_0101_1011, 7, pulses);
`ifdef SEQDET_OVERLAP_EN
      exp_pulses = 2;
`else
      exp_pulses = 1;
`endif
      check("stream7_pulses", pulses, exp_pulses);
      check("stream7_count", int'(count_a), exp_pulses);
      check("stream7_model_count", exp_cnt_a, exp_pulses);

      // Valid gaps between bits 2 and 3.
      send(1'b0, 1'b0, 1'b1);
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 1'b0, 1'b0);
         pulses += int'(match_a);
      end
      send(1'b1, 1'b1, 1'b0);
      pulses += int'(match_a);
      send(1'b1, 1'b1, 1'b0);
      pulses += int'(match_a);
      check("gap_match", int'(match_a), 1);
      check("gap_window", int'(window_a), 4'b1011);
      send(1'b0, 1'b0, 1'b0);
      pulses += int'(match_a);
      check("gap_pulses", pulses, 1);

      // clr wins over the completing bit.
      send(1'b0, 1'b0, 1'b1);
      send(1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b1);
      check("clr_match", int'(match_a), 0);
      check("clr_count", int'(count_a), 0);
      check("clr_window", int'(window_a), 0);
      send_bits(16'b0000_0000_0000_1011, 4, pulses);
      check("after_clr_match", int'(match_a), 1);

      // Saturation of the 2-bit counter.
      send(1'b0, 1'b0, 1'b1);
      pulses = 0;
      for (int i = 15; i >= 0; i--) begin
         logic [15:0] s;
         s = 16'b1011_0110_1101_1011;
         send(s[i], 1'b1, 1'b0);
         pulses += int'(match_b);
      end
`ifdef SEQDET_OVERLAP_EN
      exp_pulses = 5;
`else
      exp_pulses = 3;
`endif
      check("sat_pulses", pulses, exp_pulses);
      check("sat_count_b", int'(count_b), 3);
      check("sat_count_a", int'(count_a), exp_pulses);
      send_bits(16'b0000_0000_0000_1011, 4, pulses);
      check("sat_hold_b", int'(count_b), 3);

      // Randomized traffic with occasional clr and async reset.
      for (int n = 0; n < 3000; n++) begin
         send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 99) == 0));
         if ($urandom_range(0, 299) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
      end

      send(1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
- Consumes a registered serial bit stream, one bit per qualified clock, and detects a fixed PAT_W-bit pattern.
- Emits a 1-cycle match pulse, a saturating match counter and the current shift window.
- Sits directly downstream of the single-bit D-register stage in the serial datapath; its din is that stage's q output.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern to detect; MSB is the oldest bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only on cycles where this is 1.
- clr  input  1  synchronous clear of window, fill state, counter and match.
- match  output  1  registered pulse, high for exactly one cycle per detection.
- match_count  output  CNT_W  number of detections since reset/clr; saturates at all-ones.
- window  output  PAT_W  current shift window; LSB is the newest bit.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All outputs are registered.
- Reset: rst=1 immediately forces match=0, match_count=0, window=0 and fill state EMPTY (fill=0), regardless of clk.
- Shift: on a clk edge with din_valid=1, window <= {window[PAT_W-2:0], din}. With din_valid=0, window holds.
- Fill FSM (fill counter 0..PAT_W):
  - EMPTY (fill=0) -> FILLING on a valid bit.
  - FILLING: fill increments per valid bit; moves to ARMED when fill reaches PAT_W.
  - ARMED: fill stays at PAT_W.
- Detection: the candidate is the post-shift window value, window_next.
  - match <= din_valid & (fill_next==PAT_W) & (window_next==PATTERN).
  - Latency: match is high on the cycle after the edge that sampled the completing bit.
  - No match is possible before PAT_W valid bits have been received.
- Non-valid cycles: match <= 0. The pulse never stretches, even if din_valid stays low.
- Counter: increments by 1 on each cycle in which match is set. At 2^CNT_W-1 it holds; no wrap.
- clr:
  - Synchronous; priority over din_valid.
  - Next state: window=0, fill=0 (EMPTY), match_count=0, match=0.
  - A bit presented together with clr is discarded.
- rst asserted mid-stream: all state is lost. Detection restarts from EMPTY after rst deasserts.
- Gaps: din_valid gaps of any length between bits do not break a pattern.

Optional Feature:
- Macro: SEQDET_OVERLAP_EN.
- Defined: overlapping detection. Fill stays ARMED after a match, so PATTERN=1011 with stream 1011011 gives 2 matches.
- Undefined: non-overlapping detection. On a match, the fill FSM returns to EMPTY (fill=0); window contents are kept but ignored until PAT_W new valid bits arrive. Stream 1011011 gives 1 match.

Decomposition:
- Shared header seqdet_defs.vh holds:
  - fill-state encodings: EMPTY=2'd0, FILLING=2'd1, ARMED=2'd2;
  - default PAT_W, PATTERN and CNT_W constants;
  - the SEQDET_OVERLAP_EN default (left undefined).
- One sub-module is natural: shift_window (PAT_W-bit shift register with enable and sync clear, async rst). The top holds the fill FSM, comparator, match register and counter.

Test Plan:
- Reset mid-stream: assert rst asynchronously between edges after 3 valid bits -> outputs 0 immediately; then feed 1,0,1,1 -> match pulses exactly once, 1 cycle after the 4th bit.
- Overlap (macro defined), stream 1011011 with valid every cycle -> match after bits 4 and 7; match_count=2.
- Non-overlap (macro undefined), same stream -> a single match after bit 4; match_count=1.
- Valid gaps: bits 1,0,1,1 with din_valid low for 5 cycles between bits 2 and 3 -> one match, one cycle wide; window=4'b1011.
- clr priority: assert clr with din_valid=1 on the completing bit of 1011 -> no match, match_count=0, window=0; the next 1,0,1,1 matches.
- Saturation with CNT_W=2: feed 5 overlapping matches (1011011011011011) -> match_count reaches 3 and holds at 3; match still pulses each time.
